// File: rtl/eightmux_arbiter.sv
// Round-robin arbiter and select sequencer for the eightmux 8:1 datapath.
// Define ARB_TIMEOUT_EN to enable the HOLD_MAX forced-release timeout and the expired pulse.
module eightmux_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] select,
    output logic [7:0] gnt,
    output logic       valid,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE,
        SWITCH,
        OWN
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("eightmux_arbiter: HOLD_MAX must be in 1..255");
    end

    state_t     state_q;
    logic [2:0] select_q;
    logic [2:0] last_q;
    logic [7:0] gnt_q;
    logic       valid_q;

    // Scan starts one past base and wraps; base itself is checked last (lowest priority).
    function automatic pick_t rr_pick(input logic [7:0] r, input logic [2:0] base);
        pick_t      p;
        logic [2:0] idx;
        // NOTE: every variable gets a value before the loop, so no path leaves it unassigned.
        p   = '0;
        idx = '0;
        for (int k = 1; k <= 8; k++) begin
            idx = base + 3'(k);
            if (r[idx] && !p.found) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    logic       timeout;
    logic       release_own;
    logic [2:0] arb_base;
    pick_t      win;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] cnt_q;
    logic       expired_q;

    assign timeout = (cnt_q == HOLD_LAST) && |(req & ~gnt_q);
`else
    assign timeout = 1'b0;
`endif

    assign release_own = done || !req[select_q] || timeout;
    // On a release the holder becomes the new "last" in the same edge, so scan from it directly.
    assign arb_base    = (state_q == OWN) ? select_q : last_q;
    assign win         = rr_pick(req, arb_base);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            select_q <= 3'd0;
            last_q   <= 3'd7;
            gnt_q    <= 8'h00;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win.found) begin
                        select_q <= win.idx;
                        gnt_q    <= 8'(1) << win.idx;
                        state_q  <= SWITCH;
                    end
                end
                SWITCH: begin
                    valid_q <= 1'b1;
                    state_q <= OWN;
                end
                OWN: begin
                    if (release_own) begin
                        last_q  <= select_q;
                        valid_q <= 1'b0;
                        if (win.found) begin
                            select_q <= win.idx;
                            gnt_q    <= 8'(1) << win.idx;
                            state_q  <= SWITCH;
                        end else begin
                            gnt_q   <= 8'h00;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 8'h00;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter: cleared on entry to OWN, saturates so a late competitor releases immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (state_q == SWITCH) begin
                cnt_q <= 8'd0;
            end else if (state_q == OWN) begin
                if (cnt_q != HOLD_LAST) begin
                    cnt_q <= cnt_q + 8'd1;
                end
                expired_q <= timeout && !done && req[select_q];
            end
        end
    end

    assign expired = expired_q;
`else
    assign expired = 1'b0;
`endif

    assign select = select_q;
    assign gnt    = gnt_q;
    assign valid  = valid_q;

endmodule
